max_pool_stream: RTL and testbench
==================================

Name: max_pool_stream

Overview:
- Streaming 2x2, stride-2 signed max-pooling stage between the convolution engine and the flattening stage of the CNN.
- Consumes convolution results one value per handshake in raster order: feature-major, then row, then column.
- Emits pooled values in the same order, tagged with feature index and last flags, for the flattening stage.

Parameters:
- CONV_WIDTH, 10, convolution map width (IMAGE_WIDTH-KERNEL_SIZE+1)
- CONV_HEIGHT, 10, convolution map height
- NUM_FEATURES, 2, number of feature maps streamed back-to-back
- DATA_WIDTH, 8, signed two's-complement data width
- Derived (localparam): POOLED_WIDTH = CONV_WIDTH>>1, POOLED_HEIGHT = CONV_HEIGHT>>1

Ports:
- clk  input  1  clock, rising edge
- rst_cnn  input  1  asynchronous active-low reset
- pool_enable  input  1  active-low start; sampled only in IDLE
- conv_valid  input  1  convolution value present
- conv_data  input  DATA_WIDTH  signed convolution value
- conv_ready  output  1  stage accepts conv_data this cycle
- pool_valid  output  1  pooled value present
- pool_data  output  DATA_WIDTH  signed pooled value
- pool_feature  output  $clog2(NUM_FEATURES)+1  feature index of pool_data
- pool_last  output  1  final pooled value of the final feature
- pool_ready  input  1  downstream accepts pooled value
- pool_done  output  1  one-cycle pulse after the final output handshake

Behaviour:
- Reset (rst_cnn=0, async): state=IDLE; all counters 0; conv_ready=0, pool_valid=0, pool_data=0, pool_feature=0, pool_last=0, pool_done=0.
- Reset mid-operation aborts immediately. There is no recovery of partial data. A new pool_enable pulse is required.
- States: IDLE, EVEN_ROW, ODD_ROW, DONE.
  - IDLE: conv_ready=0. pool_enable==0 at a rising edge -> EVEN_ROW with col/row/feat counters cleared.
  - EVEN_ROW: at the last column handshake -> ODD_ROW.
  - ODD_ROW: at the last column handshake -> EVEN_ROW, or -> DONE if this was the last row of the last feature. The feature counter advances when the row counter wraps.
  - DONE: wait until the output register is empty, pulse pool_done for 1 cycle, -> IDLE.
- pool_enable low while not in IDLE: ignored.
- Input handshake: a transfer occurs when conv_valid && conv_ready. conv_ready = (state is EVEN_ROW or ODD_ROW) && (!pool_valid || pool_ready).
- Datapath:
  - Even column, any row: store the value in a pair register.
  - EVEN_ROW, odd column: write max(pair, value) into row buffer entry col>>1 (POOLED_WIDTH entries).
  - ODD_ROW, odd column: load max(pair, value, rowbuf[col>>1]) into the output register.
  - All comparisons are signed. There is no saturation and no rectification.
- Output register:
  - pool_valid is set on the cycle after the completing input handshake (latency 1).
  - It holds pool_data/pool_feature/pool_last stable until pool_valid && pool_ready.
  - A simultaneous output handshake and new load in the same cycle is legal and back-to-back.
- pool_last=1 only with the output at pooled (POOLED_HEIGHT-1, POOLED_WIDTH-1) of feature NUM_FEATURES-1.
- Odd CONV_WIDTH: the final column of each row is accepted and discarded; it writes neither the pair register nor the row buffer.
- Odd CONV_HEIGHT: the final row of each feature is accepted and discarded. If that row is the last row of the last feature, enter DONE after its last column.
- Row buffer contents are overwritten each EVEN_ROW. It needs no clear between features.
- Output count per run = POOLED_WIDTH*POOLED_HEIGHT*NUM_FEATURES (50 with defaults).

Test Plan:
- Basic pooling: CONV 4x4, 1 feature, input 0..15 row-major, pool_ready=1 -> outputs 5,7,13,15; pool_last only on 15; pool_done pulses once, 1 cycle after the output 15 handshake.
- Signed compare: CONV 2x2 input {-128,-3,-7,-100} -> single output -3 with pool_last=1.
- Back-pressure: defaults, all-ones image, pool_ready toggling 1-of-3 cycles -> 50 outputs, no loss or duplication. pool_data must stay stable while pool_valid && !pool_ready, and conv_ready must be 0 then.
- Odd dimensions: CONV 5x5, 1 feature, input 0..24 -> outputs 6,8,16,18; 25 inputs accepted; the last row and column are dropped.
- Feature ordering: defaults, feature 0 all 1s, feature 1 all -1s -> 25 outputs of 1 with pool_feature=0, then 25 outputs of -1 with pool_feature=1; pool_last only on the 50th output.
- Reset and start handling: assert rst_cnn=0 after 37 inputs -> all outputs return to reset values immediately. A restart then yields the full correct 50-output sequence. A pool_enable pulse mid-run must have no effect.

Source files
------------

// File: rtl/max_pool_stream.sv
// Streaming 2x2 / stride-2 signed max-pooling stage. Takes raster-ordered
// convolution values and emits one pooled value per 2x2 window.
module max_pool_stream #(
  parameter int CONV_WIDTH   = 10,
  parameter int CONV_HEIGHT  = 10,
  parameter int NUM_FEATURES = 2,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                                clk,
  input  logic                                rst_cnn,
  input  logic                                pool_enable,
  input  logic                                conv_valid,
  input  logic signed [DATA_WIDTH-1:0]        conv_data,
  output logic                                conv_ready,
  output logic                                pool_valid,
  output logic signed [DATA_WIDTH-1:0]        pool_data,
  output logic [$clog2(NUM_FEATURES):0]       pool_feature,
  output logic                                pool_last,
  input  logic                                pool_ready,
  output logic                                pool_done
);

  localparam int POOLED_WIDTH  = CONV_WIDTH >> 1;
  localparam int POOLED_HEIGHT = CONV_HEIGHT >> 1;
  localparam int CW = $clog2(CONV_WIDTH + 1);
  localparam int RW = $clog2(CONV_HEIGHT + 1);
  localparam int FW = $clog2(NUM_FEATURES) + 1;
  localparam int IW = (POOLED_WIDTH > 1) ? $clog2(POOLED_WIDTH) : 1;

  localparam logic [CW-1:0] COL_LAST      = CW'(CONV_WIDTH - 1);
  localparam logic [CW-1:0] COL_KEEP      = CW'(2 * POOLED_WIDTH);
  localparam logic [CW-1:0] COL_LAST_KEPT = CW'(2 * POOLED_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(CONV_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_KEEP      = RW'(2 * POOLED_HEIGHT);
  localparam logic [RW-1:0] ROW_LAST_KEPT = RW'(2 * POOLED_HEIGHT - 1);
  localparam logic [FW-1:0] FEAT_LAST     = FW'(NUM_FEATURES - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // conv_ready only depends on state and whether the output slot frees up,
  // so a stalled output also stalls the input side.
  typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW, DONE} state_t;
  state_t state;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [FW-1:0] feat;

  logic signed [DATA_WIDTH-1:0] pair;
  logic signed [DATA_WIDTH-1:0] rowbuf [POOLED_WIDTH];

  logic                         in_row;
  logic                         xfer;
  logic                         last_col;
  logic                         last_row;
  logic                         last_feat;
  logic                         col_kept;
  logic                         row_kept;
  logic                         load;
  logic [IW-1:0]                buf_idx;
  logic signed [DATA_WIDTH-1:0] pair_max;
  logic signed [DATA_WIDTH-1:0] window_max;

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign in_row     = (state == EVEN_ROW) || (state == ODD_ROW);
  assign conv_ready = in_row && (!pool_valid || pool_ready);
  assign xfer       = conv_valid && conv_ready;
  assign last_col   = (col == COL_LAST);
  assign last_row   = (row == ROW_LAST);
  assign last_feat  = (feat == FEAT_LAST);
  // A trailing odd column/row has no partner and is simply swallowed.
  assign col_kept   = (col < COL_KEEP);
  assign row_kept   = (row < ROW_KEEP);
  assign buf_idx    = IW'(col >> 1);
  assign pair_max   = smax(pair, conv_data);
  assign window_max = smax(pair_max, rowbuf[buf_idx]);
  assign load       = xfer && (state == ODD_ROW) && col[0] && col_kept && row_kept;

  // Pair register and row buffer hold no control state, so they need no reset.
  always_ff @(posedge clk) begin
    if (xfer && col_kept && row_kept) begin
      if (!col[0]) begin
        pair <= conv_data;
      end else if (state == EVEN_ROW) begin
        rowbuf[buf_idx] <= pair_max;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_cnn) begin
    if (!rst_cnn) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      feat         <= '0;
      pool_valid   <= 1'b0;
      pool_data    <= '0;
      pool_feature <= '0;
      pool_last    <= 1'b0;
      pool_done    <= 1'b0;
    end else begin
      pool_done <= 1'b0;

      if (load) begin
        pool_valid   <= 1'b1;
        pool_data    <= window_max;
        pool_feature <= feat;
        pool_last    <= last_feat && (row == ROW_LAST_KEPT) && (col == COL_LAST_KEPT);
      end else if (pool_valid && pool_ready) begin
        pool_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!pool_enable) begin
            state <= EVEN_ROW;
            col   <= '0;
            row   <= '0;
            feat  <= '0;
          end
        end
        EVEN_ROW, ODD_ROW: begin
          if (xfer) begin
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                row <= '0;
                if (last_feat) begin
                  state <= DONE;
                end else begin
                  feat  <= feat + 1'b1;
                  state <= EVEN_ROW;
                end
              end else begin
                row   <= row + 1'b1;
                state <= (state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DONE: begin
          // The output slot is empty once the pending value is taken.
          if (!pool_valid || pool_ready) begin
            pool_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max_pool_stream.sv
// Directed bench for max_pool_stream: four parameterisations share one
// stimulus bus; sel picks which instance the current scenario observes.
module tb_max_pool_stream;

  localparam int BUDGET = 3000;

  logic       clk = 1'b0;
  logic       rst_cnn;
  logic       pool_enable;
  logic       conv_valid;
  logic [7:0] conv_data;
  logic       pool_ready;

  logic       cr_def, pv_def, pl_def, pd_def;
  logic [7:0] dat_def;
  logic [1:0] pf_def;
  logic       cr_b4, pv_b4, pl_b4, pd_b4;
  logic [7:0] dat_b4;
  logic [0:0] pf_b4;
  logic       cr_s2, pv_s2, pl_s2, pd_s2;
  logic [7:0] dat_s2;
  logic [0:0] pf_s2;
  logic       cr_o5, pv_o5, pl_o5, pd_o5;
  logic [7:0] dat_o5;
  logic [0:0] pf_o5;

  int         sel;
  logic       m_ready, m_valid, m_last, m_done;
  logic [7:0] m_data;
  logic [1:0] m_feat;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  in_q[$];
  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];
  int done_cnt, done_cyc, last_hs_cyc, stall_err, ready_err, accepted;

  always #5 clk = ~clk;

  max_pool_stream u_def (
    .clk(clk), .rst_cnn(rst_cnn), .pool_enable(pool_enable),
    .conv_valid(conv_valid), .conv_data(conv_data), .conv_ready(cr_def),
    .pool_valid(pv_def), .pool_data(dat_def), .pool_feature(pf_def),
    .pool_last(pl_def), .pool_ready(pool_ready), .pool_done(pd_def)
  );

  max_pool_stream #(.CONV_WIDTH(4), .CONV_HEIGHT(4), .NUM_FEATURES(1), .DATA_WIDTH(8)) u_b4 (
    .clk(clk), .rst_cnn(rst_cnn), .pool_enable(pool_enable),
    .conv_valid(conv_valid), .conv_data(conv_data), .conv_ready(cr_b4),
    .pool_valid(pv_b4), .pool_data(dat_b4), .pool_feature(pf_b4),
    .pool_last(pl_b4), .pool_ready(pool_ready), .pool_done(pd_b4)
  );

  max_pool_stream #(.CONV_WIDTH(2), .CONV_HEIGHT(2), .NUM_FEATURES(1), .DATA_WIDTH(8)) u_s2 (
    .clk(clk), .rst_cnn(rst_cnn), .pool_enable(pool_enable),
    .conv_valid(conv_valid), .conv_data(conv_data), .conv_ready(cr_s2),
    .pool_valid(pv_s2), .pool_data(dat_s2), .pool_feature(pf_s2),
    .pool_last(pl_s2), .pool_ready(pool_ready), .pool_done(pd_s2)
  );

  max_pool_stream #(.CONV_WIDTH(5), .CONV_HEIGHT(5), .NUM_FEATURES(1), .DATA_WIDTH(8)) u_o5 (
    .clk(clk), .rst_cnn(rst_cnn), .pool_enable(pool_enable),
    .conv_valid(conv_valid), .conv_data(conv_data), .conv_ready(cr_o5),
    .pool_valid(pv_o5), .pool_data(dat_o5), .pool_feature(pf_o5),
    .pool_last(pl_o5), .pool_ready(pool_ready), .pool_done(pd_o5)
  );

  always_comb begin
    m_ready = cr_def; m_valid = pv_def; m_data = dat_def;
    m_feat  = pf_def; m_last  = pl_def; m_done = pd_def;
    case (sel)
      1: begin
        m_ready = cr_b4; m_valid = pv_b4; m_data = dat_b4;
        m_feat  = {1'b0, pf_b4}; m_last = pl_b4; m_done = pd_b4;
      end
      2: begin
        m_ready = cr_s2; m_valid = pv_s2; m_data = dat_s2;
        m_feat  = {1'b0, pf_s2}; m_last = pl_s2; m_done = pd_s2;
      end
      3: begin
        m_ready = cr_o5; m_valid = pv_o5; m_data = dat_o5;
        m_feat  = {1'b0, pf_o5}; m_last = pl_o5; m_done = pd_o5;
      end
      default: ;
    endcase
  end

  function automatic logic [10:0] pk(input logic l, input logic [1:0] f, input logic [7:0] d);
    return {l, f, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_cnn     = 1'b0;
    pool_enable = 1'b1;
    conv_valid  = 1'b0;
    conv_data   = '0;
    pool_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_cnn = 1'b1;
  endtask

  task automatic start();
    @(posedge clk); #1 pool_enable = 1'b0;
    @(posedge clk); #1 pool_enable = 1'b1;
  endtask

  // Streams in_q[0..n_in-1]; inputs change 1 time unit after posedge and
  // the handshakes due at the next posedge are recorded on the negedge.
  // rmode 0: pool_ready always 1; rmode 1: pool_ready 1 cycle in 3.
  task automatic run_stream(input int n_in, input int rmode, input int pulse_cyc, input int abort_at);
    int          idx = 0;
    int          cyc = 0;
    logic        stall = 1'b0;
    logic [10:0] held = '0;
    logic [10:0] cur;
    got_q.delete();
    done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
    stall_err = 0; ready_err = 0; accepted = 0;
    forever begin
      @(posedge clk); #1;
      conv_valid  = (idx < n_in);
      conv_data   = (idx < n_in) ? in_q[idx] : 8'h00;
      pool_ready  = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
      pool_enable = (cyc == pulse_cyc) ? 1'b0 : 1'b1;
      @(negedge clk);
      cur = pk(m_last, m_feat, m_data);
      if (stall && (!m_valid || cur !== held)) stall_err++;
      if (m_valid && !pool_ready && m_ready) ready_err++;
      stall = m_valid && !pool_ready;
      held  = cur;
      if (m_valid && pool_ready) begin
        got_q.push_back(cur);
        last_hs_cyc = cyc;
      end
      if (m_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (conv_valid && m_ready) idx++;
      accepted = idx;
      cyc++;
      if (abort_at > 0 && idx == abort_at) break;
      if (done_cnt > 0 && cyc > done_cyc + 4) break;
      if (cyc >= BUDGET) begin
        n_cmp++; n_err++;
        $display("FAIL stream_timeout: %0d inputs, %0d outputs after %0d cycles, required pool_done", idx, got_q.size(), cyc);
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_cnn = 1'b0; pool_enable = 1'b1; conv_valid = 1'b0; pool_ready = 1'b1;
    #3;
    n_cmp++;
    if ({cr_def, pv_def, dat_def, pf_def, pl_def, pd_def} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0", {cr_def, pv_def, dat_def, pf_def, pl_def, pd_def});
    end
    do_reset();
  endtask

  task automatic test_basic();
    sel = 1;
    do_reset(); start();
    in_q.delete();
    for (int i = 0; i < 20; i++) in_q.push_back(8'(i));
    exp_q.delete();
    exp_q.push_back(pk(1'b0, 2'd0, 8'd5));
    exp_q.push_back(pk(1'b0, 2'd0, 8'd7));
    exp_q.push_back(pk(1'b0, 2'd0, 8'd13));
    exp_q.push_back(pk(1'b1, 2'd0, 8'd15));
    run_stream(20, 0, -1, 0);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL basic_count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL basic_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (accepted !== 16) begin
      n_err++; $display("FAIL basic_accepted: got %0d required 16", accepted);
    end
    n_cmp++;
    if (done_cnt !== 1) begin
      n_err++; $display("FAIL basic_done_count: got %0d required 1", done_cnt);
    end
    n_cmp++;
    if (done_cyc - last_hs_cyc !== 1) begin
      n_err++; $display("FAIL basic_done_delay: got %0d cycles required 1", done_cyc - last_hs_cyc);
    end
  endtask

  task automatic test_signed();
    sel = 2;
    do_reset(); start();
    in_q.delete();
    in_q.push_back(8'sd0 - 8'sd128);
    in_q.push_back(-8'sd3);
    in_q.push_back(-8'sd7);
    in_q.push_back(-8'sd100);
    run_stream(4, 0, -1, 0);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++; $display("FAIL signed_count: got %0d outputs, required 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      n_cmp++;
      if (got_q[0] !== pk(1'b1, 2'd0, 8'hFD)) begin
        n_err++; $display("FAIL signed_out: got %h required %h", got_q[0], pk(1'b1, 2'd0, 8'hFD));
      end
    end
  endtask

  task automatic test_odd_dims();
    sel = 3;
    do_reset(); start();
    in_q.delete();
    for (int i = 0; i < 30; i++) in_q.push_back(8'(i));
    exp_q.delete();
    exp_q.push_back(pk(1'b0, 2'd0, 8'd6));
    exp_q.push_back(pk(1'b0, 2'd0, 8'd8));
    exp_q.push_back(pk(1'b0, 2'd0, 8'd16));
    exp_q.push_back(pk(1'b1, 2'd0, 8'd18));
    run_stream(30, 0, -1, 0);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL odd_count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL odd_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (accepted !== 25) begin
      n_err++; $display("FAIL odd_accepted: got %0d required 25", accepted);
    end
    n_cmp++;
    if (done_cnt !== 1) begin
      n_err++; $display("FAIL odd_done_count: got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    sel = 0;
    do_reset(); start();
    in_q.delete();
    for (int i = 0; i < 200; i++) in_q.push_back(8'd1);
    exp_q.delete();
    for (int i = 0; i < 50; i++) exp_q.push_back(pk(i == 49, 2'(i / 25), 8'd1));
    run_stream(200, 1, -1, 0);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL bp_count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL bp_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (stall_err !== 0) begin
      n_err++; $display("FAIL bp_stable: got %0d unstable stall cycles, required 0", stall_err);
    end
    n_cmp++;
    if (ready_err !== 0) begin
      n_err++; $display("FAIL bp_conv_ready: got %0d stall cycles with conv_ready=1, required 0", ready_err);
    end
    n_cmp++;
    if (done_cnt !== 1) begin
      n_err++; $display("FAIL bp_done_count: got %0d required 1", done_cnt);
    end
  endtask

  task automatic load_features();
    in_q.delete();
    for (int i = 0; i < 100; i++) in_q.push_back(8'd1);
    for (int i = 0; i < 100; i++) in_q.push_back(8'hFF);
    exp_q.delete();
    for (int i = 0; i < 25; i++) exp_q.push_back(pk(1'b0, 2'd0, 8'd1));
    for (int i = 0; i < 25; i++) exp_q.push_back(pk(i == 24, 2'd1, 8'hFF));
  endtask

  task automatic test_features();
    sel = 0;
    do_reset(); start();
    load_features();
    run_stream(200, 0, -1, 0);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL feat_count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL feat_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort_restart();
    int idle_err = 0;
    sel = 0;
    do_reset(); start();
    load_features();
    run_stream(200, 1, -1, 37);
    @(posedge clk); #1;
    rst_cnn = 1'b0;
    #1;
    n_cmp++;
    if ({m_ready, m_valid, m_data, m_feat, m_last, m_done} !== 14'h0) begin
      n_err++;
      $display("FAIL abort_outputs: got %h required 0", {m_ready, m_valid, m_data, m_feat, m_last, m_done});
    end
    @(posedge clk); #1 rst_cnn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 conv_valid = 1'b1; pool_ready = 1'b1;
      @(negedge clk);
      if (m_ready || m_valid) idle_err++;
    end
    n_cmp++;
    if (idle_err !== 0) begin
      n_err++; $display("FAIL abort_idle: got %0d active cycles without start, required 0", idle_err);
    end
    conv_valid = 1'b0;
    start();
    run_stream(200, 0, 60, 0);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL restart_count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL restart_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (done_cnt !== 1) begin
      n_err++; $display("FAIL restart_done_count: got %0d required 1", done_cnt);
    end
  endtask

  initial begin
    sel = 0;
    test_reset();
    test_basic();
    test_signed();
    test_odd_dims();
    test_back_to_back();
    test_features();
    test_abort_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
